ram_cmd_arb: RTL

RAM_CMD_ARB -- requirements
Module: ram_cmd_arb

---
 rtl/ram_cmd_arb_if.sv | 34 +++
 rtl/ram_cmd_arb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arb_if.sv
// Command/read-response bundle between a RAM client and the RAM command port.
// master drives commands and accepts responses; slave accepts commands and returns responses.
interface ram_cmd_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) ();
   logic [ID_WIDTH-1:0]   cmd_id;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wr_data;
   logic [STRB_WIDTH-1:0] cmd_wr_strb;
   logic                  cmd_wr_en;
   logic                  cmd_rd_en;
   logic                  cmd_last;
   logic                  cmd_ready;
   logic [ID_WIDTH-1:0]   rd_resp_id;
   logic [DATA_WIDTH-1:0] rd_resp_data;
   logic                  rd_resp_last;
   logic                  rd_resp_valid;
   logic                  rd_resp_ready;

   modport master (
      output cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
      output rd_resp_ready,
      input  cmd_ready, rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid
   );

   modport slave (
      input  cmd_id, cmd_addr, cmd_wr_data, cmd_wr_strb, cmd_wr_en, cmd_rd_en, cmd_last,
      input  rd_resp_ready,
      output cmd_ready, rd_resp_id, rd_resp_data, rd_resp_last, rd_resp_valid
   );
endinterface

// File: rtl/ram_cmd_arb.sv
// Two-port RAM command arbiter: round-robin beat grant with burst locking, and a
// read-tag FIFO that steers in-order read responses back to the issuing port.
module ram_cmd_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int TAG_DEPTH  = 16
) (
   input logic     clk,
   input logic     rst,
   ram_cmd_if.slave  s0,
   ram_cmd_if.slave  s1,
   ram_cmd_if.master m
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             lock_q, lock_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             tag_mem_q [TAG_DEPTH];
   logic             tag_mem_d [TAG_DEPTH];

   logic [1:0]            elig;
   logic                  full, empty;
   logic                  gnt_vld, gnt, sel;
   logic                  accept, push, pop, head, resp_ready;
   logic [ID_WIDTH-1:0]   mux_id;
   logic [ADDR_WIDTH-1:0] mux_addr;
   logic [DATA_WIDTH-1:0] mux_data;
   logic [STRB_WIDTH-1:0] mux_strb;
   logic                  mux_wr_en, mux_rd_en, mux_last;

   // Reads stall while every tag slot is in use; writes never need a tag.
   always_comb begin
      full    = (count_q == CNT_W'(TAG_DEPTH));
      empty   = (count_q == '0);
      elig[0] = s0.cmd_wr_en | (s0.cmd_rd_en & ~full);
      elig[1] = s1.cmd_wr_en | (s1.cmd_rd_en & ~full);
   end

   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 1'b0;
      if (lock_q) begin
         gnt     = owner_q;
         gnt_vld = elig[owner_q];
      end else if (elig[0] && elig[1]) begin
         gnt_vld = 1'b1;
         gnt     = ~last_grant_q;
      end else if (elig[0]) begin
         gnt_vld = 1'b1;
         gnt     = 1'b0;
      end else if (elig[1]) begin
         gnt_vld = 1'b1;
         gnt     = 1'b1;
      end
   end

   // With no grant the fields follow port 0 and both enables are forced low.
   always_comb begin
      sel       = gnt_vld & gnt;
      mux_id    = sel ? s1.cmd_id      : s0.cmd_id;
      mux_addr  = sel ? s1.cmd_addr    : s0.cmd_addr;
      mux_data  = sel ? s1.cmd_wr_data : s0.cmd_wr_data;
      mux_strb  = sel ? s1.cmd_wr_strb : s0.cmd_wr_strb;
      mux_last  = sel ? s1.cmd_last    : s0.cmd_last;
      mux_wr_en = gnt_vld & (sel ? s1.cmd_wr_en : s0.cmd_wr_en);
      mux_rd_en = gnt_vld & (sel ? s1.cmd_rd_en : s0.cmd_rd_en);
      accept    = m.cmd_ready & (mux_wr_en | mux_rd_en);
      push      = accept & mux_rd_en;
   end

   assign m.cmd_id      = mux_id;
   assign m.cmd_addr    = mux_addr;
   assign m.cmd_wr_data = mux_data;
   assign m.cmd_wr_strb = mux_strb;
   assign m.cmd_wr_en   = mux_wr_en;
   assign m.cmd_rd_en   = mux_rd_en;
   assign m.cmd_last    = mux_last;
   assign s0.cmd_ready  = m.cmd_ready & gnt_vld & ~gnt;
   assign s1.cmd_ready  = m.cmd_ready & gnt_vld & gnt;

   // Response steering: the FIFO head names the port that owns the next read beat.
   always_comb begin
      head       = tag_mem_q[rptr_q];
      resp_ready = ~empty & (head ? s1.rd_resp_ready : s0.rd_resp_ready);
      pop        = m.rd_resp_valid & resp_ready;
   end

   assign m.rd_resp_ready = resp_ready;
   assign s0.rd_resp_valid = m.rd_resp_valid & ~empty & ~head;
   assign s1.rd_resp_valid = m.rd_resp_valid & ~empty & head;
   assign s0.rd_resp_id    = m.rd_resp_id;
   assign s1.rd_resp_id    = m.rd_resp_id;
   assign s0.rd_resp_data  = m.rd_resp_data;
   assign s1.rd_resp_data  = m.rd_resp_data;
   assign s0.rd_resp_last  = m.rd_resp_last;
   assign s1.rd_resp_last  = m.rd_resp_last;

   always_comb begin
      lock_d       = lock_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      tag_mem_d    = tag_mem_q;
      if (accept) begin
         last_grant_d = gnt;
         lock_d       = ~mux_last;
         if (!mux_last) begin
            owner_d = gnt;
         end
      end
      if (push) begin
         tag_mem_d[wptr_q] = gnt;
      end
      wptr_d  = wptr_q + PTR_W'(push);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Port 1 is preset as the last grant so port 0 wins the first contention.
   always_ff @(posedge clk) begin
      tag_mem_q <= tag_mem_d;
      if (rst) begin
         lock_q       <= 1'b0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
      end else begin
         lock_q       <= lock_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         count_q      <= count_d;
      end
   end
endmodule
